// File: rtl/packet_detector_ctrl_if.sv
// Sample-in, ALU and result bundle of the packet detector sequencer.
// slave: the sequencer itself; master: the surrounding front end / ALU / framing.
interface packet_detector_ctrl_if;
   logic         in_valid_i;
   logic         in_ready_o;
   logic [15:0]  in_i_i;
   logic [15:0]  in_q_i;
   logic [2:0]   alu_mode_o;
   logic [367:0] alu_samples_o;
   logic [15:0]  alu_res_i;
   logic         out_valid_o;
   logic [15:0]  power_o;
   logic [15:0]  level_o;
   logic         hit_o;
   logic         pkt_det_o;

   modport slave (
      input  in_valid_i, in_i_i, in_q_i, alu_res_i,
      output in_ready_o, alu_mode_o, alu_samples_o,
             out_valid_o, power_o, level_o, hit_o, pkt_det_o
   );

   modport master (
      output in_valid_i, in_i_i, in_q_i, alu_res_i,
      input  in_ready_o, alu_mode_o, alu_samples_o,
             out_valid_o, power_o, level_o, hit_o, pkt_det_o
   );
endinterface

// File: rtl/packet_detector_ctrl.sv
// Packet detector sequencer: time-shares an external ALU to compute power,
// 23-tap window sum, average and scaled threshold for each accepted I/Q
// sample, then decides hit / packet start with hit and hold-off counters.
module packet_detector_ctrl #(
   parameter int unsigned HITS    = 3,
   parameter int unsigned HOLDOFF = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en_i,
   input  logic                  clear_i,
   input  logic [15:0]           thresh_i,
   output logic                  busy_o,
   packet_detector_ctrl_if.slave bus
);
   localparam int unsigned TAPS      = 23;
   localparam logic [4:0]  FILL_MAX  = 5'(TAPS);
   localparam logic [3:0]  HITS_C    = 4'(HITS);
   localparam logic [7:0]  HOLDOFF_C = 8'(HOLDOFF);

   typedef enum logic [2:0] {
      S_IDLE, S_POW, S_SUM, S_AVG, S_SCALE, S_DECIDE
   } state_t;

   typedef enum logic [2:0] {
      OP_SUM  = 3'd0,
      OP_POW  = 3'd1,
      OP_MULT = 3'd2,
      OP_SHR  = 3'd3,
      OP_IDLE = 3'd4
   } alu_op_t;

   state_t              state, state_nxt;
   alu_op_t             alu_op;
   logic [16*TAPS-1:0]  samples;
   logic                ready, accept;

   logic [15:0]         win [TAPS];
   logic [15:0]         samp_i, samp_q;
   logic [15:0]         pwr, sum, avg, level;
   logic [4:0]          fill;
   logic [3:0]          hit_cnt, hit_cnt_inc;
   logic [7:0]          holdoff;
   logic                hit, det;

   logic                out_valid, hit_q, det_q;
   logic [15:0]         power_q, level_q;

   // State register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state, ALU opcode/operands and sample handshake
   always_comb begin
      state_nxt = state;
      alu_op    = OP_IDLE;
      samples   = '0;
      ready     = 1'b0;
      accept    = 1'b0;
      case (state)
         S_IDLE: begin
            ready  = en_i & ~clear_i & rst;
            accept = bus.in_valid_i & ready;
            if (accept) begin
               state_nxt = S_POW;
            end
         end
         S_POW: begin
            alu_op         = OP_POW;
            samples[15:0]  = samp_i;
            samples[31:16] = samp_q;
            state_nxt      = S_SUM;
         end
         S_SUM: begin
            alu_op = OP_SUM;
            for (int unsigned k = 0; k < TAPS; k++) begin
               samples[16*k +: 16] = win[k];
            end
            state_nxt = S_AVG;
         end
         S_AVG: begin
            alu_op        = OP_SHR;
            samples[15:0] = sum;
            state_nxt     = S_SCALE;
         end
         S_SCALE: begin
            alu_op         = OP_MULT;
            samples[15:0]  = thresh_i;
            samples[31:16] = avg;
            state_nxt      = S_DECIDE;
         end
         S_DECIDE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
      if (clear_i) begin
         state_nxt = S_IDLE;
      end
   end

   // Decision on the current sample: hit only once the window is full
   always_comb begin
      hit         = (fill == FILL_MAX) && ($signed(pwr) > $signed(level));
      hit_cnt_inc = hit_cnt + 4'd1;
      det         = (holdoff == '0) && hit && (hit_cnt_inc == HITS_C);
   end

   // Datapath: capture sample, register ALU results, window and counters
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned k = 0; k < TAPS; k++) begin
            win[k] <= '0;
         end
         fill    <= '0;
         hit_cnt <= '0;
         holdoff <= '0;
         sum     <= '0;
         avg     <= '0;
         pwr     <= '0;
         level   <= '0;
         samp_i  <= '0;
         samp_q  <= '0;
      end else if (clear_i) begin
         for (int unsigned k = 0; k < TAPS; k++) begin
            win[k] <= '0;
         end
         fill    <= '0;
         hit_cnt <= '0;
         holdoff <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  samp_i <= bus.in_i_i;
                  samp_q <= bus.in_q_i;
               end
            end
            S_POW: begin
               pwr    <= bus.alu_res_i;
               win[0] <= bus.alu_res_i;
               for (int unsigned k = 1; k < TAPS; k++) begin
                  win[k] <= win[k-1];
               end
               if (fill != FILL_MAX) begin
                  fill <= fill + 5'd1;
               end
            end
            S_SUM:   sum   <= bus.alu_res_i;
            S_AVG:   avg   <= bus.alu_res_i;
            S_SCALE: level <= bus.alu_res_i;
            S_DECIDE: begin
               if (holdoff != '0) begin
                  holdoff <= holdoff - 8'd1;
                  hit_cnt <= '0;
               end else if (hit) begin
                  if (det) begin
                     hit_cnt <= '0;
                     holdoff <= HOLDOFF_C;
                  end else begin
                     hit_cnt <= hit_cnt_inc;
                  end
               end else begin
                  hit_cnt <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // Result registers: one-cycle strobe after DECIDE, power/level hold otherwise
   always_ff @(posedge clk) begin
      if (!rst) begin
         out_valid <= 1'b0;
         hit_q     <= 1'b0;
         det_q     <= 1'b0;
         power_q   <= '0;
         level_q   <= '0;
      end else begin
         out_valid <= 1'b0;
         hit_q     <= 1'b0;
         det_q     <= 1'b0;
         if ((state == S_DECIDE) && !clear_i) begin
            out_valid <= 1'b1;
            hit_q     <= hit;
            det_q     <= det;
            power_q   <= pwr;
            level_q   <= level;
         end
      end
   end

   assign busy_o            = (state != S_IDLE);
   assign bus.in_ready_o    = ready;
   assign bus.alu_mode_o    = alu_op;
   assign bus.alu_samples_o = samples;
   assign bus.out_valid_o   = out_valid;
   assign bus.power_o       = power_q;
   assign bus.level_o       = level_q;
   assign bus.hit_o         = hit_q;
   assign bus.pkt_det_o     = det_q;
endmodule

// File: doc/packet_detector_ctrl.md
Name: packet_detector_ctrl

Overview:
Sequencer that time-shares the packet detector ALU to run a sliding-window energy detector on a complex I/Q stream. For each accepted sample it drives the ALU through four operations: power, 23-tap sum, average, then threshold scale. It keeps the 23-entry power window and the hit/hold-off counters, and flags packet starts. It sits between the sample front end and the packet framing logic. The ALU is instantiated outside this block.

Parameters:
HITS, 3, consecutive over-threshold decisions required to declare a packet (1..15)
HOLDOFF, 32, processed samples after a detection during which no new detection is raised (0..255)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
en_i  in  1  enable; low = accept no new samples
clear_i  in  1  flush window and counters
thresh_i  in  16  signed Q3.12 threshold factor, must be positive
in_valid_i  in  1  sample valid
in_ready_o  out  1  sample accept
in_i_i  in  16  signed I sample
in_q_i  in  16  signed Q sample
alu_mode_o  out  3  ALU opcode: 0 SUM_23, 1 CMPLX_ABS_POW, 2 MULT, 3 SHIFT_RIGHT, 4 ALU_IDLE
alu_samples_o  out  368  packed ALU operands; slice k = bits [16k+15:16k] = sample k
alu_res_i  in  16  ALU combinational result
out_valid_o  out  1  one-cycle result strobe
power_o  out  16  power of the decided sample
level_o  out  16  scaled threshold level
hit_o  out  1  power_o > level_o with window full
pkt_det_o  out  1  packet detected (valid with out_valid_o)
busy_o  out  1  state != IDLE

Behaviour:
- Reset (rst=0 at edge): state IDLE. Window entries, sum, avg, fill counter, hit counter and hold-off counter are cleared to 0. All outputs are 0, except alu_mode_o=4. in_ready_o=0 during the reset cycle.
- States: IDLE -> POW -> SUM -> AVG -> SCALE -> DECIDE -> IDLE. Each non-IDLE state lasts exactly 1 cycle. The ALU result is registered at the end of each state.
- IDLE: in_ready_o = en_i & ~clear_i. alu_mode_o=4 and all operand slices are 0. On in_valid_i & in_ready_o, capture I/Q and go to POW.
- POW: mode 1, slice0=I, slice1=Q. p = alu_res_i. Shift the window (entry0=p, oldest dropped). fill = min(fill+1, 23).
- SUM: mode 0, slices 0..22 = window entries. sum = alu_res_i (16-bit wrap, as the ALU produces).
- AVG: mode 3, slice0=sum. avg = alu_res_i (sum>>>4).
- SCALE: mode 2, slice0=thresh_i, slice1=avg. level = alu_res_i.
- DECIDE: mode 4. hit = (fill==23) & ($signed(p) > $signed(level)).
  - If holdoff>0: decrement holdoff and force hit_cnt=0.
  - Else if hit: hit_cnt+1. If the new count == HITS, set det=1, hit_cnt=0, holdoff=HOLDOFF.
  - Else (no hit): hit_cnt=0.
- Output: registered at the DECIDE edge. The cycle after DECIDE (back in IDLE) has out_valid_o=1 for exactly 1 cycle, with power_o=p, level_o=level, hit_o, and pkt_det_o=det. Otherwise pkt_det_o and hit_o are 0, and power_o/level_o hold their last value.
- Latency: acceptance edge at cycle 0, out_valid_o high in cycle 6. A new sample can be accepted in cycle 6. Throughput is 1 sample per 6 cycles.
- Operand slices not listed for a state are driven 0.
- en_i low mid-sequence: the current sample completes normally. Only acceptance is blocked.
- clear_i in any state: next state is IDLE and the in-flight sample is dropped (no out_valid_o). Window, fill, hit_cnt and holdoff are cleared to 0. clear_i has priority over in_valid_i.
- rst in mid-sequence: same as reset; the in-flight sample is dropped.
- fill saturates at 23. No decision can hit before 23 samples have been processed since reset or clear.

Test Plan:
- Reset/idle: hold rst=0 for 3 cycles, then release with in_valid_i=0 -> alu_mode_o=4, alu_samples_o=0, in_ready_o=1, busy_o=0, all outputs 0.
- Warm-up: thresh_i=0x2000, 23 samples I=Q=0x0040 -> each yields power_o=2. On the 23rd sample level_o=4, hit_o=0, pkt_det_o=0. Check the ALU mode sequence 1,0,3,2,4 and out_valid_o 6 cycles after each accept.
- Detection: after the warm-up, 3 samples I=Q=0x0400 -> power_o=512 each, level_o=68, 132, 196 in turn, hit_o=1 each time. pkt_det_o=1 on the 3rd sample only.
- Hold-off: HOLDOFF=4, continue with I=Q=0x0400 -> hit_o=1 but pkt_det_o=0 for the next 4 samples. A new detection occurs only after HITS further hits.
- Clear/abort: assert clear_i during SUM -> no out_valid_o, state IDLE next cycle. The next 22 samples give hit_o=0 regardless of power.
- Backpressure/enable: in_valid_i held high with en_i toggled low during SCALE -> current result still emitted, no accept while en_i=0. in_valid_i & clear_i together -> sample not accepted.
